vga_timing_core: RTL and testbench
==================================

// Module: vga_timing_core
// PURPOSE
//  Parametrised VGA raster engine: shadowed H/V timing config, sync/DE generation, pixel-stream intake.
//  Sits between the APB config register bank (cfg_* inputs) and the pads.
//  Pulls pixels over a valid/ready stream from the framebuffer fetch FIFO.
//  Adds sync polarity, frame-boundary config update, underrun detection and an end-of-active IRQ.
// PARAMETERS
//  CNT_WIDTH  12  width of every size field and of the h/v position counters
//  RGB_WIDTH  16  pixel width (RGB565 by default)
// PORTS
//  pclk            in   1          pixel clock
//  prst            in   1          asynchronous, active-high reset
//  en_i            in   1          raster enable (ctrl bit)
//  hpol_i/vpol_i   in   1          sync active level (1 = active-high)
//  cfg_hv/hfp/hsn/hbp_i  in CNT_WIDTH  horizontal visible/front porch/sync/back porch sizes (pixels)
//  cfg_vv/vfp/vsn/vbp_i  in CNT_WIDTH  vertical sizes (lines)
//  pix_valid_i     in   1          pixel data valid
//  pix_data_i      in   RGB_WIDTH  pixel data
//  pix_ready_o     out  1          pixel accepted this cycle when pix_valid_i is also high
//  vga_hsync_o     out  1          horizontal sync
//  vga_vsync_o     out  1          vertical sync
//  vga_de_o        out  1          display enable
//  vga_rgb_o       out  RGB_WIDTH  pixel out; 0 outside DE and on underrun
//  hcnt_o/vcnt_o   out  CNT_WIDTH  stage-1 raster position
//  frame_irq_o     out  1          1-cycle pulse at the first pixel of vertical front porch
//  underrun_o      out  1          sticky: ready asserted while valid low
//  underrun_clr_i  in   1          clears underrun_o
// BEHAVIOUR
//  Reset: counters 0; de/irq/underrun/rgb/pix_ready 0; syncs = inactive level (~pol); shadows 0.
//  Shadow regs: all cfg_* and pol copied when en_i==0 (every cycle) and on the last pixel of a frame.
//   A size of 0 is loaded as 1. Mid-frame cfg writes never affect the current frame.
//  Totals: htot = hv+hfp+hsn+hbp, vtot likewise, computed at CNT_WIDTH+2 bits, no overflow.
//   Counters are CNT_WIDTH+2 bits internally; hcnt_o/vcnt_o are the low CNT_WIDTH bits.
//  Stage 1 (registered position): hcnt 0..htot-1 wraps to 0 and increments vcnt.
//   vcnt 0..vtot-1 wraps to 0 (frame end).
//   pix_ready_o = de_s1 = (hcnt<hv)&&(vcnt<vv).
//  Stage 2 (pads, +1 cycle after stage 1):
//   vga_hsync_o active iff hv+hfp <= hcnt < hv+hfp+hsn.
//   vga_vsync_o active iff vv+vfp <= vcnt < vv+vfp+vsn; changes only with hcnt==0.
//   vga_de_o = de_s1 delayed.
//   vga_rgb_o = pix_data_i if de_s1&&pix_valid_i, else 0.
//  Handshake: a pixel is consumed only when pix_ready_o&&pix_valid_i. The block never stalls; missing pixel = underrun.
//  Underrun: set on de_s1&&!pix_valid_i. Clear on underrun_clr_i. Set wins when both occur in the same cycle.
//  frame_irq_o: pulses for 1 cycle when stage 1 enters (hcnt==0, vcnt==vv), delivered in stage 2.
//  en_i fall mid-frame: next cycle counters return to 0, pix_ready_o=0, syncs inactive, de 0. No partial line is finished.
//  en_i rise: first enabled cycle has stage 1 at (0,0) with new shadows; vga_de_o rises 1 cycle later.
//  Async prst mid-frame: immediate return to reset values; a frame in progress is discarded.
// TESTING
//  hv=4,hfp=1,hsn=2,hbp=1,vv=2,vfp=1,vsn=1,vbp=1, valid=1 -> htot=8; 8 hcnt cycles per line, 5 lines per frame.
//   Same config: hsync active at hcnt 5..6 (+1 lag); vsync active for line 3; de for 4 pixels on lines 0-1.
//  Polarity: hpol=0 -> hsync idles 1 and pulses 0. Reset -> syncs idle at ~pol, rgb=0.
//  Change cfg_hv 4->6 mid-frame -> current frame keeps 8-cycle lines; next frame htot=10.
//  Drop pix_valid_i for 1 active pixel -> that rgb=0, underrun_o=1 and stays set. Clear + set in the same cycle -> stays 1.
//  en_i low at line 1 hcnt 2 -> next cycle hcnt=vcnt=0, de=0. en_i high -> (0,0) restart.
//  Field=0 programmed -> treated as 1. CNT_WIDTH=12 with all fields 4095 -> htot=16380, no wrap error.

Source files
------------

// File: rtl/vga_timing_core.sv
// vga_timing_core
//
// Parametrised VGA raster engine. Sits between the configuration register
// bank (cfg_* inputs) and the display pads. It pulls pixels from the
// framebuffer fetch FIFO over a valid/ready stream.
//
// Pipeline
//   stage 1 : registered raster position (hcnt/vcnt) plus the registered
//             active-area flag that drives pix_ready_o.
//   stage 2 : registered pad outputs (syncs, DE, RGB, frame IRQ), one cycle
//             behind stage 1.
//
// Ports
//   pclk, prst              pixel clock, asynchronous active-high reset
//   en_i                    raster enable
//   hpol_i, vpol_i          sync active level (1 = active-high)
//   cfg_h*_i, cfg_v*_i      visible / front porch / sync / back porch sizes
//   pix_valid_i, pix_data_i pixel stream from the fetch FIFO
//   pix_ready_o             pixel consumed when pix_valid_i is also high
//   vga_hsync_o/vsync_o     sync pads
//   vga_de_o, vga_rgb_o     display enable and pixel (0 outside DE/underrun)
//   hcnt_o, vcnt_o          stage-1 raster position (low CNT_WIDTH bits)
//   frame_irq_o             1-cycle pulse at the first vertical front porch pixel
//   underrun_o              sticky underrun flag, cleared by underrun_clr_i
//
// Configuration (sizes and polarities) is captured in shadow registers while
// the raster is disabled and on the last pixel of each frame, so register
// writes mid-frame only take effect from the next frame on.

module vga_timing_core #(
  parameter int CNT_WIDTH = 12,
  parameter int RGB_WIDTH = 16
) (
  input  logic                 pclk,
  input  logic                 prst,
  input  logic                 en_i,
  input  logic                 hpol_i,
  input  logic                 vpol_i,
  input  logic [CNT_WIDTH-1:0] cfg_hv_i,
  input  logic [CNT_WIDTH-1:0] cfg_hfp_i,
  input  logic [CNT_WIDTH-1:0] cfg_hsn_i,
  input  logic [CNT_WIDTH-1:0] cfg_hbp_i,
  input  logic [CNT_WIDTH-1:0] cfg_vv_i,
  input  logic [CNT_WIDTH-1:0] cfg_vfp_i,
  input  logic [CNT_WIDTH-1:0] cfg_vsn_i,
  input  logic [CNT_WIDTH-1:0] cfg_vbp_i,
  input  logic                 pix_valid_i,
  input  logic [RGB_WIDTH-1:0] pix_data_i,
  output logic                 pix_ready_o,
  output logic                 vga_hsync_o,
  output logic                 vga_vsync_o,
  output logic                 vga_de_o,
  output logic [RGB_WIDTH-1:0] vga_rgb_o,
  output logic [CNT_WIDTH-1:0] hcnt_o,
  output logic [CNT_WIDTH-1:0] vcnt_o,
  output logic                 frame_irq_o,
  output logic                 underrun_o,
  input  logic                 underrun_clr_i
);

  // Two extra bits: the sum of four CNT_WIDTH fields never overflows.
  localparam int PW = CNT_WIDTH + 2;
  localparam logic [PW-1:0] ZERO_C = {PW{1'b0}};
  localparam logic [PW-1:0] ONE_C  = {{(PW-1){1'b0}}, 1'b1};

  // A programmed size of zero would make the counters never match their
  // terminal value, so it is promoted to one on capture.
  function automatic logic [PW-1:0] fix_size(input logic [CNT_WIDTH-1:0] size);
    logic [PW-1:0] res;
    if (size == {CNT_WIDTH{1'b0}}) begin
      res = ONE_C;
    end else begin
      res = {2'b00, size};
    end
    return res;
  endfunction

  // Shadow configuration (current frame)
  logic [PW-1:0] sh_hv_r, sh_hfp_r, sh_hsn_r, sh_hbp_r;
  logic [PW-1:0] sh_vv_r, sh_vfp_r, sh_vsn_r, sh_vbp_r;
  logic          sh_hpol_r, sh_vpol_r;
  logic [PW-1:0] sh_hv_s, sh_hfp_s, sh_hsn_s, sh_hbp_s;
  logic [PW-1:0] sh_vv_s, sh_vfp_s, sh_vsn_s, sh_vbp_s;
  logic          sh_hpol_s, sh_vpol_s;

  // Stage 1
  logic          active_r, active_s;
  logic [PW-1:0] hcnt_r, hcnt_s;
  logic [PW-1:0] vcnt_r, vcnt_s;
  logic          de_s1_r, de_s1_s;

  // Stage 2
  logic                 hsync_r, hsync_s;
  logic                 vsync_r, vsync_s;
  logic                 de2_r, de2_s;
  logic [RGB_WIDTH-1:0] rgb_r, rgb_s;
  logic                 irq_r, irq_s;
  logic                 underrun_r, underrun_s;

  // Decoded timing of the current frame
  logic [PW-1:0] htot_s, vtot_s;
  logic [PW-1:0] hs_start_s, hs_stop_s, vs_start_s, vs_stop_s;
  logic          h_last_s, v_last_s, frame_end_s, load_s, run_s;
  logic          h_act_s, v_act_s;

  // Frame totals, sync windows and frame-boundary detection
  always_comb begin
    htot_s      = sh_hv_r + sh_hfp_r + sh_hsn_r + sh_hbp_r;
    vtot_s      = sh_vv_r + sh_vfp_r + sh_vsn_r + sh_vbp_r;
    hs_start_s  = sh_hv_r + sh_hfp_r;
    hs_stop_s   = hs_start_s + sh_hsn_r;
    vs_start_s  = sh_vv_r + sh_vfp_r;
    vs_stop_s   = vs_start_s + sh_vsn_r;
    h_last_s    = (hcnt_r == (htot_s - ONE_C));
    v_last_s    = (vcnt_r == (vtot_s - ONE_C));
    frame_end_s = active_r && h_last_s && v_last_s;
    // Shadows track the inputs while disabled and reload at frame end.
    load_s      = !en_i || frame_end_s;
    // Stage 1 holds a real raster position only while enabled and running.
    run_s       = en_i && active_r;
  end

  // Shadow register next state
  always_comb begin
    if (load_s) begin
      sh_hv_s   = fix_size(cfg_hv_i);
      sh_hfp_s  = fix_size(cfg_hfp_i);
      sh_hsn_s  = fix_size(cfg_hsn_i);
      sh_hbp_s  = fix_size(cfg_hbp_i);
      sh_vv_s   = fix_size(cfg_vv_i);
      sh_vfp_s  = fix_size(cfg_vfp_i);
      sh_vsn_s  = fix_size(cfg_vsn_i);
      sh_vbp_s  = fix_size(cfg_vbp_i);
      sh_hpol_s = hpol_i;
      sh_vpol_s = vpol_i;
    end else begin
      sh_hv_s   = sh_hv_r;
      sh_hfp_s  = sh_hfp_r;
      sh_hsn_s  = sh_hsn_r;
      sh_hbp_s  = sh_hbp_r;
      sh_vv_s   = sh_vv_r;
      sh_vfp_s  = sh_vfp_r;
      sh_vsn_s  = sh_vsn_r;
      sh_vbp_s  = sh_vbp_r;
      sh_hpol_s = sh_hpol_r;
      sh_vpol_s = sh_vpol_r;
    end
  end

  // Stage 1 next state: raster counters and the active-area flag
  always_comb begin
    hcnt_s   = ZERO_C;
    vcnt_s   = ZERO_C;
    active_s = 1'b0;
    if (!en_i) begin
      // Disabled: park at (0,0); any partial line is abandoned.
      active_s = 1'b0;
    end else if (!active_r) begin
      // First enabled cycle starts the frame at (0,0).
      active_s = 1'b1;
    end else begin
      active_s = 1'b1;
      if (h_last_s) begin
        hcnt_s = ZERO_C;
        if (v_last_s) begin
          vcnt_s = ZERO_C;
        end else begin
          vcnt_s = vcnt_r + ONE_C;
        end
      end else begin
        hcnt_s = hcnt_r + ONE_C;
        vcnt_s = vcnt_r;
      end
    end
    // Uses the next shadows so a new frame is judged by its own sizes.
    de_s1_s = active_s && (hcnt_s < sh_hv_s) && (vcnt_s < sh_vv_s);
  end

  // Stage 2 next state: pads, pixel capture, IRQ and underrun flag
  always_comb begin
    h_act_s = (hcnt_r >= hs_start_s) && (hcnt_r < hs_stop_s);
    // vcnt only moves on a line wrap, so vsync edges align with hcnt==0.
    v_act_s = (vcnt_r >= vs_start_s) && (vcnt_r < vs_stop_s);
    if (run_s && h_act_s) begin
      hsync_s = sh_hpol_r;
    end else begin
      hsync_s = ~sh_hpol_r;
    end
    if (run_s && v_act_s) begin
      vsync_s = sh_vpol_r;
    end else begin
      vsync_s = ~sh_vpol_r;
    end
    de2_s = en_i && de_s1_r;
    if (en_i && de_s1_r && pix_valid_i) begin
      rgb_s = pix_data_i;
    end else begin
      rgb_s = {RGB_WIDTH{1'b0}};
    end
    irq_s = run_s && (hcnt_r == ZERO_C) && (vcnt_r == sh_vv_r);
    // A new underrun takes priority over a simultaneous clear.
    if (de_s1_r && !pix_valid_i) begin
      underrun_s = 1'b1;
    end else if (underrun_clr_i) begin
      underrun_s = 1'b0;
    end else begin
      underrun_s = underrun_r;
    end
  end

  // State registers for shadows, stage 1 and stage 2
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      sh_hv_r    <= ZERO_C;
      sh_hfp_r   <= ZERO_C;
      sh_hsn_r   <= ZERO_C;
      sh_hbp_r   <= ZERO_C;
      sh_vv_r    <= ZERO_C;
      sh_vfp_r   <= ZERO_C;
      sh_vsn_r   <= ZERO_C;
      sh_vbp_r   <= ZERO_C;
      sh_hpol_r  <= 1'b0;
      sh_vpol_r  <= 1'b0;
      active_r   <= 1'b0;
      hcnt_r     <= ZERO_C;
      vcnt_r     <= ZERO_C;
      de_s1_r    <= 1'b0;
      // Inactive level of the reset polarity shadow (0) is high.
      hsync_r    <= 1'b1;
      vsync_r    <= 1'b1;
      de2_r      <= 1'b0;
      rgb_r      <= {RGB_WIDTH{1'b0}};
      irq_r      <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      sh_hv_r    <= sh_hv_s;
      sh_hfp_r   <= sh_hfp_s;
      sh_hsn_r   <= sh_hsn_s;
      sh_hbp_r   <= sh_hbp_s;
      sh_vv_r    <= sh_vv_s;
      sh_vfp_r   <= sh_vfp_s;
      sh_vsn_r   <= sh_vsn_s;
      sh_vbp_r   <= sh_vbp_s;
      sh_hpol_r  <= sh_hpol_s;
      sh_vpol_r  <= sh_vpol_s;
      active_r   <= active_s;
      hcnt_r     <= hcnt_s;
      vcnt_r     <= vcnt_s;
      de_s1_r    <= de_s1_s;
      hsync_r    <= hsync_s;
      vsync_r    <= vsync_s;
      de2_r      <= de2_s;
      rgb_r      <= rgb_s;
      irq_r      <= irq_s;
      underrun_r <= underrun_s;
    end
  end

  assign pix_ready_o = de_s1_r;
  assign hcnt_o      = hcnt_r[CNT_WIDTH-1:0];
  assign vcnt_o      = vcnt_r[CNT_WIDTH-1:0];
  assign vga_hsync_o = hsync_r;
  assign vga_vsync_o = vsync_r;
  assign vga_de_o    = de2_r;
  assign vga_rgb_o   = rgb_r;
  assign frame_irq_o = irq_r;
  assign underrun_o  = underrun_r;

endmodule

// File: tb/tb_vga_timing_core.sv
// Testbench for vga_timing_core: behavioural raster model compared on every
// cycle, directed literal expectations, then randomized stimulus.

module tb_vga_timing_core;

  logic        pclk = 1'b0;
  logic        prst = 1'b1;
  logic        en_i = 1'b0;
  logic        hpol_i = 1'b0;
  logic        vpol_i = 1'b0;
  logic [11:0] cfg_hv_i = 12'd0, cfg_hfp_i = 12'd0, cfg_hsn_i = 12'd0, cfg_hbp_i = 12'd0;
  logic [11:0] cfg_vv_i = 12'd0, cfg_vfp_i = 12'd0, cfg_vsn_i = 12'd0, cfg_vbp_i = 12'd0;
  logic        pix_valid_i = 1'b1;
  logic [15:0] pix_data_i = 16'd0;
  logic        underrun_clr_i = 1'b0;
  logic        pix_ready_o, vga_hsync_o, vga_vsync_o, vga_de_o, frame_irq_o, underrun_o;
  logic [15:0] vga_rgb_o;
  logic [11:0] hcnt_o, vcnt_o;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  vga_timing_core #(.CNT_WIDTH(12), .RGB_WIDTH(16)) dut (
    .pclk(pclk), .prst(prst), .en_i(en_i), .hpol_i(hpol_i), .vpol_i(vpol_i),
    .cfg_hv_i(cfg_hv_i), .cfg_hfp_i(cfg_hfp_i), .cfg_hsn_i(cfg_hsn_i), .cfg_hbp_i(cfg_hbp_i),
    .cfg_vv_i(cfg_vv_i), .cfg_vfp_i(cfg_vfp_i), .cfg_vsn_i(cfg_vsn_i), .cfg_vbp_i(cfg_vbp_i),
    .pix_valid_i(pix_valid_i), .pix_data_i(pix_data_i), .pix_ready_o(pix_ready_o),
    .vga_hsync_o(vga_hsync_o), .vga_vsync_o(vga_vsync_o), .vga_de_o(vga_de_o),
    .vga_rgb_o(vga_rgb_o), .hcnt_o(hcnt_o), .vcnt_o(vcnt_o), .frame_irq_o(frame_irq_o),
    .underrun_o(underrun_o), .underrun_clr_i(underrun_clr_i)
  );

  always #5 pclk = ~pclk;

  // ---------------- behavioural model ----------------
  typedef struct {
    int hv, hfp, hsn, hbp, vv, vfp, vsn, vbp;
    bit hp, vp;
  } par_t;

  typedef struct {
    par_t        p;
    bit          run;
    int          x, y;
    bit          hs, vs, de, irq, ur;
    logic [15:0] rgb;
  } mst_t;

  mst_t m;

  function automatic int nz(input logic [11:0] v);
    return (v == 12'd0) ? 1 : int'(v);
  endfunction

  function automatic par_t cap_cfg();
    par_t p;
    p.hv = nz(cfg_hv_i); p.hfp = nz(cfg_hfp_i); p.hsn = nz(cfg_hsn_i); p.hbp = nz(cfg_hbp_i);
    p.vv = nz(cfg_vv_i); p.vfp = nz(cfg_vfp_i); p.vsn = nz(cfg_vsn_i); p.vbp = nz(cfg_vbp_i);
    p.hp = hpol_i; p.vp = vpol_i;
    return p;
  endfunction

  function automatic mst_t m_rst();
    mst_t n;
    n.p = '{0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0};
    n.run = 1'b0; n.x = 0; n.y = 0;
    n.hs = 1'b1; n.vs = 1'b1; n.de = 1'b0; n.irq = 1'b0; n.ur = 1'b0; n.rgb = 16'd0;
    return n;
  endfunction

  function automatic bit ready_of(input mst_t c);
    return c.run && (c.x < c.p.hv) && (c.y < c.p.vv);
  endfunction

  // One pixel clock of the raster rules, in plain integer arithmetic.
  function automatic mst_t m_next(input mst_t c, input bit en, input bit valid,
                                  input logic [15:0] data, input bit clr, input par_t newp);
    mst_t n;
    int htot, vtot;
    bit rdy, live, in_hs, in_vs, last;
    n = c;
    htot  = c.p.hv + c.p.hfp + c.p.hsn + c.p.hbp;
    vtot  = c.p.vv + c.p.vfp + c.p.vsn + c.p.vbp;
    rdy   = ready_of(c);
    live  = en && c.run;
    in_hs = (c.x >= c.p.hv + c.p.hfp) && (c.x < c.p.hv + c.p.hfp + c.p.hsn);
    in_vs = (c.y >= c.p.vv + c.p.vfp) && (c.y < c.p.vv + c.p.vfp + c.p.vsn);
    n.hs  = (live && in_hs) ? c.p.hp : !c.p.hp;
    n.vs  = (live && in_vs) ? c.p.vp : !c.p.vp;
    n.de  = en && rdy;
    n.rgb = (en && rdy && valid) ? data : 16'd0;
    n.irq = live && (c.x == 0) && (c.y == c.p.vv);
    if (rdy && !valid) n.ur = 1'b1;
    else if (clr) n.ur = 1'b0;
    last = c.run && (c.x == htot - 1) && (c.y == vtot - 1);
    if (!en) begin
      n.run = 1'b0; n.x = 0; n.y = 0; n.p = newp;
    end else if (!c.run) begin
      n.run = 1'b1; n.x = 0; n.y = 0;
    end else begin
      n.x = (c.x + 1) % htot;
      if (n.x == 0) n.y = (c.y + 1) % vtot;
      if (last) n.p = newp;
    end
    return n;
  endfunction

  always @(posedge pclk or posedge prst) begin
    if (prst) m <= m_rst();
    else      m <= m_next(m, en_i, pix_valid_i, pix_data_i, underrun_clr_i, cap_cfg());
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge pclk) begin
    if (chk_on) begin
      check("ready", pix_ready_o, ready_of(m));
      check("hsync", vga_hsync_o, m.hs);
      check("vsync", vga_vsync_o, m.vs);
      check("de", vga_de_o, m.de);
      check("rgb", vga_rgb_o, m.rgb);
      check("irq", frame_irq_o, m.irq);
      check("underrun", underrun_o, m.ur);
      check("hcnt", hcnt_o, 64'(m.x & 32'hFFF));
      check("vcnt", vcnt_o, 64'(m.y & 32'hFFF));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge pclk);
    pix_data_i = 16'($urandom);
  endtask

  task automatic idle_load(input int hv, hfp, hsn, hbp, vv, vfp, vsn, vbp, input bit hp, vp);
    en_i = 1'b0;
    cfg_hv_i = 12'(hv); cfg_hfp_i = 12'(hfp); cfg_hsn_i = 12'(hsn); cfg_hbp_i = 12'(hbp);
    cfg_vv_i = 12'(vv); cfg_vfp_i = 12'(vfp); cfg_vsn_i = 12'(vsn); cfg_vbp_i = 12'(vbp);
    hpol_i = hp; vpol_i = vp;
    pix_valid_i = 1'b1; underrun_clr_i = 1'b0;
    repeat (3) step();
  endtask

  // Run 48 cycles of the reference 8x5 raster, collecting pad waveforms.
  task automatic capture(input bit hp, output logic [47:0] hs, output logic [47:0] vs,
                         output logic [47:0] de, output logic [47:0] irq);
    idle_load(4, 1, 2, 1, 2, 1, 1, 1, hp, 1'b1);
    en_i = 1'b1;
    for (int k = 0; k < 48; k++) begin
      step();
      hs[k] = vga_hsync_o; vs[k] = vga_vsync_o; de[k] = vga_de_o; irq[k] = frame_irq_o;
      if (k == 15) check("line_end_hcnt", hcnt_o, 64'd7);
      if (k == 16) check("line2_vcnt", vcnt_o, 64'd2);
    end
  endtask

  logic [47:0] c_hs, c_vs, c_de, c_irq;

  initial begin
    // Reset values (polarity inputs low -> idle syncs high)
    repeat (2) @(posedge pclk);
    chk_on = 1'b1;
    @(negedge pclk);
    check("rst_hsync", vga_hsync_o, 64'd1);
    check("rst_vsync", vga_vsync_o, 64'd1);
    check("rst_de", vga_de_o, 64'd0);
    check("rst_rgb", vga_rgb_o, 64'd0);
    check("rst_ready", pix_ready_o, 64'd0);
    prst = 1'b0;

    // Reference raster, active-high syncs
    capture(1'b1, c_hs, c_vs, c_de, c_irq);
    check("ref_hsync_wave", c_hs, 48'hC0C0_C0C0_C0C0);
    check("ref_vsync_wave", c_vs, 48'h0001_FE00_0000);
    check("ref_de_wave", c_de, 48'h1E00_0000_1E1E);
    check("ref_irq_wave", c_irq, 48'h0000_0002_0000);

    // Active-low hsync
    capture(1'b0, c_hs, c_vs, c_de, c_irq);
    check("neg_hsync_wave", c_hs, 48'h3F3F_3F3F_3F3F);
    check("neg_vsync_wave", c_vs, 48'h0001_FE00_0000);

    // Mid-frame hv change takes effect next frame
    idle_load(4, 1, 2, 1, 2, 1, 1, 1, 1'b1, 1'b1);
    en_i = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      if (k == 5) cfg_hv_i = 12'd6;
      if (k == 39) begin check("old_frame_hcnt", hcnt_o, 64'd7); check("old_frame_vcnt", vcnt_o, 64'd4); end
      if (k == 49) begin check("new_frame_hcnt", hcnt_o, 64'd9); check("new_frame_vcnt", vcnt_o, 64'd0); end
    end

    // Underrun, sticky, set-over-clear, then clear
    idle_load(4, 1, 2, 1, 2, 1, 1, 1, 1'b1, 1'b1);
    underrun_clr_i = 1'b1;
    step();
    underrun_clr_i = 1'b0;
    en_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      pix_valid_i = 1'b1; underrun_clr_i = 1'b0;
      if (k == 1) begin check("ur_rgb_zero", vga_rgb_o, 64'd0); check("ur_set", underrun_o, 64'd1); end
      if (k == 2) check("ur_sticky", underrun_o, 64'd1);
      if (k == 4) check("ur_set_wins", underrun_o, 64'd1);
      if (k == 5) check("ur_cleared", underrun_o, 64'd0);
      if (k == 0) pix_valid_i = 1'b0;
      if (k == 3) begin pix_valid_i = 1'b0; underrun_clr_i = 1'b1; end
      if (k == 4) underrun_clr_i = 1'b1;
    end

    // Enable drop at line 1 hcnt 2, then restart
    idle_load(4, 1, 2, 1, 2, 1, 1, 1, 1'b1, 1'b1);
    en_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 10) begin check("pre_drop_hcnt", hcnt_o, 64'd2); check("pre_drop_vcnt", vcnt_o, 64'd1); en_i = 1'b0; end
      if (k == 11) begin
        check("drop_hcnt", hcnt_o, 64'd0); check("drop_vcnt", vcnt_o, 64'd0);
        check("drop_de", vga_de_o, 64'd0); check("drop_ready", pix_ready_o, 64'd0);
        check("drop_hsync", vga_hsync_o, 64'd0);
      end
      if (k == 12) en_i = 1'b1;
      if (k == 13) begin check("restart_ready", pix_ready_o, 64'd1); check("restart_de", vga_de_o, 64'd0); end
      if (k == 14) check("restart_de_late", vga_de_o, 64'd1);
    end

    // Zero-sized fields behave as one
    idle_load(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    en_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 3) check("zero_hcnt_last", hcnt_o, 64'd3);
      if (k == 4) begin check("zero_hcnt_wrap", hcnt_o, 64'd0); check("zero_vcnt", vcnt_o, 64'd1); end
    end

    // Maximum field sizes: htot = 16380
    idle_load(4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095, 1'b1, 1'b1);
    en_i = 1'b1;
    for (int k = 0; k < 16382; k++) begin
      step();
      if (k == 16379) begin check("max_hcnt_last", hcnt_o, 64'd4091); check("max_vcnt0", vcnt_o, 64'd0); end
      if (k == 16380) begin check("max_hcnt_wrap", hcnt_o, 64'd0); check("max_vcnt1", vcnt_o, 64'd1); end
    end

    // Asynchronous reset mid-frame
    #2 prst = 1'b1;
    #1;
    check("arst_hcnt", hcnt_o, 64'd0);
    check("arst_de", vga_de_o, 64'd0);
    check("arst_ready", pix_ready_o, 64'd0);
    check("arst_hsync", vga_hsync_o, 64'd1);
    check("arst_rgb", vga_rgb_o, 64'd0);
    en_i = 1'b0;
    step();
    prst = 1'b0;

    // Randomized traffic with mid-frame config, polarity and enable changes
    idle_load(3, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b0);
    en_i = 1'b1;
    for (int n = 0; n < 8000; n++) begin
      step();
      pix_valid_i = ($urandom_range(0, 9) != 0);
      underrun_clr_i = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 39) == 0) begin
        cfg_hv_i = 12'($urandom_range(0, 5)); cfg_hfp_i = 12'($urandom_range(0, 5));
        cfg_hsn_i = 12'($urandom_range(0, 5)); cfg_hbp_i = 12'($urandom_range(0, 5));
        cfg_vv_i = 12'($urandom_range(0, 5)); cfg_vfp_i = 12'($urandom_range(0, 5));
        cfg_vsn_i = 12'($urandom_range(0, 5)); cfg_vbp_i = 12'($urandom_range(0, 5));
      end
      if ($urandom_range(0, 99) == 0) begin
        hpol_i = 1'($urandom_range(0, 1)); vpol_i = 1'($urandom_range(0, 1));
      end
      if (en_i) en_i = ($urandom_range(0, 299) != 0);
      else      en_i = ($urandom_range(0, 3) == 0);
    end

    step();
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
